// File: rtl/fetch_pf.sv
// fetch_pf: single-outstanding instruction fetch sequencer.
// Sequence: IDLE -> FETCH -> WAIT -> DELIVER -> EXEC.
// - Issues a one-cycle read strobe at the current PC.
// - Waits MEM_LAT cycles and latches the returned word.
// - Holds the word until the consumer takes it.
// - On the retire strobe, updates the PC from the retired instruction's
//   control-flow fields.
// Optional feature macro: FETCH_PERF_EN adds saturating instruction and
// taken-branch counters (instr_cnt, br_taken_cnt).
module fetch_pf #(
  parameter int ADDR_W   = 16,
  parameter int MEM_LAT  = 1,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_start,
  input  logic [3:0]        opCode_in,
  input  logic [10:0]       offset_in,
  input  logic [ADDR_W-1:0] reg_in,
  input  logic [2:0]        br_nzp,
  input  logic [2:0]        result_nzp,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] mem_rdata,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] addr_out,
  output logic              wea_out,
  output logic              rd_en,
  output logic [ADDR_W-1:0] instr_out,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
`ifdef FETCH_PERF_EN
  output logic [15:0]       instr_cnt,
  output logic [15:0]       br_taken_cnt,
`endif
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_DELIVER = 3'd3,
    S_EXEC    = 3'd4
  } state_t;

  localparam logic [2:0]        LAT_LOAD = 3'(MEM_LAT - 1);
  localparam logic [ADDR_W-1:0] PC_RST   = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_instr;
  logic              r_rd_en;
  logic              r_valid;
  logic              r_busy;
  logic [2:0]        r_lat_cnt;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_br_off;
  logic [ADDR_W-1:0] w_jsr_off;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_br_taken;

  // Next-PC selection from the retiring instruction's opcode and fields.
  always_comb begin
    w_pc_inc   = r_pc + PC_ONE;
    w_br_off   = {{(ADDR_W-9){offset_in[8]}}, offset_in[8:0]};
    w_jsr_off  = {{(ADDR_W-11){offset_in[10]}}, offset_in[10:0]};
    w_next_pc  = w_pc_inc;
    w_br_taken = 1'b0;
    case (opCode_in)
      4'b0000: begin
        if ((br_nzp & result_nzp) != 3'b000) begin
          w_next_pc  = w_pc_inc + w_br_off;
          w_br_taken = 1'b1;
        end else begin
          w_next_pc  = w_pc_inc;
          w_br_taken = 1'b0;
        end
      end
      4'b1100: w_next_pc = reg_in;
      4'b0100: begin
        // JSR vs JSRR is chosen by the mode bit of the fetched word itself.
        if (r_instr[11]) begin
          w_next_pc = w_pc_inc + w_jsr_off;
        end else begin
          w_next_pc = reg_in;
        end
      end
      default: w_next_pc = w_pc_inc;
    endcase
  end

  // Fetch sequencer; every output is a register updated on the transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= PC_RST;
      r_addr    <= {ADDR_W{1'b0}};
      r_instr   <= {ADDR_W{1'b0}};
      r_rd_en   <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_lat_cnt <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (fetch_start) begin
            r_state <= S_FETCH;
            r_rd_en <= 1'b1;
            r_addr  <= r_pc;
            r_busy  <= 1'b1;
          end else begin
            r_rd_en <= 1'b0;
            r_addr  <= {ADDR_W{1'b0}};
            r_busy  <= 1'b0;
          end
        end
        S_FETCH: begin
          // Strobe lasts exactly one cycle; address stays on the bus.
          r_rd_en   <= 1'b0;
          r_lat_cnt <= LAT_LOAD;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (r_lat_cnt == 3'd0) begin
            r_instr <= mem_rdata;
            r_valid <= 1'b1;
            r_state <= S_DELIVER;
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end
        S_DELIVER: begin
          if (r_valid && instr_ready) begin
            r_valid <= 1'b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_valid <= 1'b0;
          if (redirect_valid) begin
            r_pc <= w_next_pc;
            if (fetch_start) begin
              r_state <= S_FETCH;
              r_rd_en <= 1'b1;
              r_addr  <= w_next_pc;
            end else begin
              r_state <= S_IDLE;
              r_addr  <= {ADDR_W{1'b0}};
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_addr    <= {ADDR_W{1'b0}};
          r_rd_en   <= 1'b0;
          r_valid   <= 1'b0;
          r_busy    <= 1'b0;
          r_lat_cnt <= 3'd0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] r_instr_cnt;
  logic [15:0] r_br_taken_cnt;

  // Saturating counters of delivered instructions and taken branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt    <= 16'h0000;
      r_br_taken_cnt <= 16'h0000;
    end else begin
      if ((r_state == S_DELIVER) && r_valid && instr_ready &&
          (r_instr_cnt != 16'hFFFF)) begin
        r_instr_cnt <= r_instr_cnt + 16'h0001;
      end
      if ((r_state == S_EXEC) && redirect_valid && w_br_taken &&
          (r_br_taken_cnt != 16'hFFFF)) begin
        r_br_taken_cnt <= r_br_taken_cnt + 16'h0001;
      end
    end
  end

  assign instr_cnt    = r_instr_cnt;
  assign br_taken_cnt = r_br_taken_cnt;
`endif

  assign addr_out    = r_addr;
  assign wea_out     = 1'b0;
  assign rd_en       = r_rd_en;
  assign instr_out   = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign busy        = r_busy;

endmodule

// File: tb/tb_fetch_pf.sv
// Randomized scoreboard bench for fetch_pf.
// The stimulus side pushes expected fetch addresses and words into queues.
// A negedge monitor pops and compares whenever the DUT strobes rd_en or
// hands over an instruction.
module tb_fetch_pf;
  localparam int ADDR_W   = 16;
  localparam int MEM_LAT  = 1;
  localparam int RESET_PC = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_start;
  logic [3:0]  opCode_in;
  logic [10:0] offset_in;
  logic [15:0] reg_in;
  logic [2:0]  br_nzp;
  logic [2:0]  result_nzp;
  logic        redirect_valid;
  logic [15:0] mem_rdata;
  logic        instr_ready;
  logic [15:0] addr_out;
  logic        wea_out;
  logic        rd_en;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic [15:0] pc;
  logic        busy;
`ifdef FETCH_PERF_EN
  logic [15:0] instr_cnt;
  logic [15:0] br_taken_cnt;
`endif

  fetch_pf #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start),
    .opCode_in(opCode_in), .offset_in(offset_in), .reg_in(reg_in),
    .br_nzp(br_nzp), .result_nzp(result_nzp), .redirect_valid(redirect_valid),
    .mem_rdata(mem_rdata), .instr_ready(instr_ready), .addr_out(addr_out),
    .wea_out(wea_out), .rd_en(rd_en), .instr_out(instr_out),
    .instr_valid(instr_valid), .pc(pc),
`ifdef FETCH_PERF_EN
    .instr_cnt(instr_cnt), .br_taken_cnt(br_taken_cnt),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_word_q[$];
  logic [15:0] imem [logic [15:0]];
  logic [15:0] model_pc;
  int model_icnt  = 0;
  int model_brcnt = 0;

  task automatic finish_test();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
    finish_test();
  endtask

  // Reference next-PC from the ISA rules, in plain integer arithmetic.
  function automatic logic [15:0] ref_next(input logic [15:0] p, input logic [3:0] op,
                                           input logic [10:0] off, input logic [15:0] r,
                                           input logic [2:0] bn, input logic [2:0] rn,
                                           input logic [15:0] w);
    int base;
    int sbr;
    int sj;
    int res;
    base = int'(p) + 1;
    sbr  = int'(off[8:0]);
    if (sbr >= 256) sbr = sbr - 512;
    sj = int'(off);
    if (sj >= 1024) sj = sj - 2048;
    if (op == 4'd0)       res = ((bn & rn) != 3'b000) ? base + sbr : base;
    else if (op == 4'd12) res = int'(r);
    else if (op == 4'd4)  res = w[11] ? base + sj : int'(r);
    else                  res = base;
    return 16'((res + 131072) % 65536);
  endfunction

  // Memory model: read data is valid only in the MEM_LAT-th cycle after rd_en.
  int          mem_cnt = 0;
  logic [15:0] mem_a   = 16'h0000;
  initial begin
    mem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) mem_rdata = imem.exists(mem_a) ? imem[mem_a] : 16'hDEAD;
        else mem_rdata = 16'($urandom);
      end else begin
        mem_rdata = 16'($urandom);
      end
      @(negedge clk);
      if (rd_en === 1'b1) begin
        mem_cnt = MEM_LAT;
        mem_a   = addr_out;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT fetches or hands over a word.
  bit          tracking = 1'b0;
  int          lat = 0;
  bit          prev_valid = 1'b0;
  bit          prev_hs = 1'b0;
  logic [15:0] prev_out = 16'h0000;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        tracking   = 1'b0;
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
      end else begin
        chk("wea_out", 32'(wea_out), 32'd0);
        if (rd_en === 1'b1) begin
          if (exp_addr_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_en_unexpected: got addr %0h expected no fetch", addr_out);
          end else begin
            logic [15:0] a;
            a = exp_addr_q.pop_front();
            chk("fetch_addr", 32'(addr_out), 32'(a));
            chk("fetch_pc", 32'(pc), 32'(a));
            chk("fetch_busy", 32'(busy), 32'd1);
          end
          tracking = 1'b1;
          lat = 0;
        end else if (tracking) begin
          lat++;
        end
        if (prev_valid && !prev_hs) begin
          chk("hold_valid", 32'(instr_valid), 32'd1);
          chk("hold_data", 32'(instr_out), 32'(prev_out));
        end
        if (instr_valid === 1'b1) begin
          if (tracking) begin
            chk("latency", 32'(lat), 32'(MEM_LAT + 1));
            tracking = 1'b0;
          end
          if (exp_word_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL valid_unexpected: got instr %0h expected no valid", instr_out);
          end else if (instr_ready === 1'b1) begin
            logic [15:0] w;
            w = exp_word_q.pop_front();
            chk("instr_out", 32'(instr_out), 32'(w));
          end
        end
        prev_valid = (instr_valid === 1'b1);
        prev_hs    = (instr_valid === 1'b1) && (instr_ready === 1'b1);
        prev_out   = instr_out;
      end
    end
  end

  // One complete instruction: fetch, handover after `stall` cycles, retire.
  task automatic do_instr(input logic [15:0] word, input logic [3:0] op,
                          input logic [10:0] off, input logic [15:0] regv,
                          input logic [2:0] bn, input logic [2:0] rn,
                          input bit go, input int stall, input bit drop);
    int n;
    int d;
    imem[model_pc] = word;
    exp_addr_q.push_back(model_pc);
    exp_word_q.push_back(word);
    instr_ready = (stall == 0);
    fetch_start = 1'b1;
    if (stall > 0) begin
      // A retire strobe outside EXEC must not touch the PC.
      @(posedge clk); #1;
      redirect_valid = 1'b1;
      opCode_in = 4'b1100;
      reg_in = 16'($urandom);
      @(posedge clk); #1;
      redirect_valid = 1'b0;
    end
    n = 0;
    while (instr_valid !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 100) timeout("wait_valid");
    end
    if (drop) fetch_start = 1'b0;
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
      instr_ready = 1'b1;
    end
    @(posedge clk); #1;
    instr_ready = 1'b0;
    d = $urandom_range(0, 2);
    repeat (d) begin @(posedge clk); #1; end
    opCode_in = op; offset_in = off; reg_in = regv; br_nzp = bn; result_nzp = rn;
    redirect_valid = 1'b1;
    fetch_start = go;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    opCode_in = 4'($urandom); offset_in = 11'($urandom); reg_in = 16'($urandom);
    model_icnt++;
    if ((op == 4'd0) && ((bn & rn) != 3'b000)) model_brcnt++;
    model_pc = ref_next(model_pc, op, off, regv, bn, rn, word);
    if (!go) begin
      chk("idle_pc", 32'(pc), 32'(model_pc));
      chk("idle_busy", 32'(busy), 32'd0);
      repeat (2) begin @(posedge clk); #1; end
      chk("idle_pc_hold", 32'(pc), 32'(model_pc));
      chk("idle_addr", 32'(addr_out), 32'd0);
      chk("idle_rd_en", 32'(rd_en), 32'd0);
    end
  endtask

  initial begin
    #3000000;
    timeout("watchdog");
  end

  initial begin
    logic [3:0] op;
    rst_n = 1'b0; fetch_start = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    opCode_in = 4'd0; offset_in = 11'd0; reg_in = 16'd0; br_nzp = 3'd0; result_nzp = 3'd0;
    model_pc = 16'(RESET_PC);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_addr", 32'(addr_out), 32'd0);
    chk("post_rst_wea", 32'(wea_out), 32'd0);
    chk("post_rst_pc", 32'(pc), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Directed control-flow cases.
    do_instr(16'h1234, 4'b1100, 11'h000, 16'h0010, 3'b000, 3'b000, 1'b1, 0, 1'b0);
    chk("jmp_0010", 32'(pc), 32'h0010);
    do_instr(16'h0000, 4'b0000, 11'h1FE, 16'h0000, 3'b101, 3'b001, 1'b1, 1, 1'b0);
    chk("br_taken_back", 32'(pc), 32'h000F);
    do_instr(16'hC000, 4'b1100, 11'h000, 16'h0010, 3'b000, 3'b000, 1'b1, 0, 1'b0);
    do_instr(16'h0000, 4'b0000, 11'h1FE, 16'h0000, 3'b101, 3'b010, 1'b1, 2, 1'b0);
    chk("br_not_taken", 32'(pc), 32'h0011);
    do_instr(16'hC000, 4'b1100, 11'h000, 16'h3000, 3'b000, 3'b000, 1'b1, 0, 1'b0);
    chk("jmp_3000", 32'(pc), 32'h3000);
    do_instr(16'hC000, 4'b1100, 11'h000, 16'hFFFF, 3'b000, 3'b000, 1'b1, 0, 1'b0);
    do_instr(16'h1021, 4'b0001, 11'h000, 16'h0000, 3'b000, 3'b000, 1'b1, 0, 1'b0);
    chk("pc_wrap", 32'(pc), 32'h0000);
    do_instr(16'h0000, 4'b0000, 11'h0FF, 16'h0000, 3'b000, 3'b111, 1'b1, 0, 1'b0);
    chk("br_nzp_zero", 32'(pc), 32'h0001);
    do_instr(16'h4800, 4'b0100, 11'h7FF, 16'h5555, 3'b000, 3'b000, 1'b1, 0, 1'b0);
    chk("jsr_offset", 32'(pc), 32'h0001);
    do_instr(16'h4000, 4'b0100, 11'h7FF, 16'h1234, 3'b000, 3'b000, 1'b1, 1, 1'b0);
    chk("jsrr_reg", 32'(pc), 32'h1234);
    do_instr(16'h0000, 4'b0000, 11'h0FF, 16'h0000, 3'b111, 3'b100, 1'b1, 0, 1'b1);
    chk("br_fwd", 32'(pc), 32'h1334);
    do_instr(16'hBEEF, 4'b0001, 11'h000, 16'h0000, 3'b000, 3'b000, 1'b0, 4, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: op = 4'b0000;
        1: op = 4'b1100;
        2: op = 4'b0100;
        default: op = 4'($urandom);
      endcase
      do_instr(16'($urandom), op, 11'($urandom), 16'($urandom), 3'($urandom), 3'($urandom),
               (i == 149) ? 1'b0 : ($urandom_range(0, 4) != 0), $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0));
    end

`ifdef FETCH_PERF_EN
    chk("instr_cnt_model", 32'(instr_cnt), 32'(model_icnt));
    chk("br_cnt_model", 32'(br_taken_cnt), 32'(model_brcnt));
`endif

    // Reset while WAIT: fetch abandoned, no valid ever appears.
    imem[model_pc] = 16'hA5A5;
    exp_addr_q.push_back(model_pc);
    exp_word_q.push_back(16'hA5A5);
    fetch_start = 1'b1;
    begin
      int n;
      n = 0;
      while (rd_en !== 1'b1) begin
        @(negedge clk);
        n++;
        if (n > 20) timeout("wait_rd_en");
      end
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_word_q.delete();
    exp_addr_q.delete();
    fetch_start = 1'b0;
    model_pc = 16'(RESET_PC);
    model_icnt = 0;
    model_brcnt = 0;
    chk("arst_pc", 32'(pc), 32'(RESET_PC));
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rd_en", 32'(rd_en), 32'd0);
    chk("arst_addr", 32'(addr_out), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("after_arst_valid", 32'(instr_valid), 32'd0);
    chk("after_arst_pc", 32'(pc), 32'(RESET_PC));
`ifdef FETCH_PERF_EN
    chk("instr_cnt_rst", 32'(instr_cnt), 32'd0);
    chk("br_cnt_rst", 32'(br_taken_cnt), 32'd0);
`endif

    // Three instructions, two of them taken branches.
    do_instr(16'h0E02, 4'b0000, 11'h002, 16'h0000, 3'b111, 3'b010, 1'b1, 0, 1'b0);
    do_instr(16'h0E05, 4'b0000, 11'h005, 16'h0000, 3'b010, 3'b010, 1'b1, 1, 1'b0);
    do_instr(16'h1021, 4'b0001, 11'h000, 16'h0000, 3'b000, 3'b000, 1'b0, 0, 1'b0);
    chk("final_pc", 32'(pc), 32'(model_pc));
`ifdef FETCH_PERF_EN
    chk("instr_cnt_3", 32'(instr_cnt), 32'd3);
    chk("br_cnt_2", 32'(br_taken_cnt), 32'd2);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("queues_drained", 32'(exp_addr_q.size() + exp_word_q.size()), 32'd0);
    finish_test();
  end
endmodule
